// File: rtl/umich_add_arbiter.sv
// Round-robin arbiter sharing one adder and one left shifter among NREQ requesters.
// Optional per-requester grant counters are enabled with `define UMICH_ARB_STATS_EN.
module umich_add_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 64,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clocked_on,
    input  logic                  preset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
`ifdef UMICH_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]    grant_cnt,
    input  logic                  stats_clr
`endif
);

    localparam int unsigned N = NREQ;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [IDW-1:0]   r_id;

    logic             w_open;
    logic             w_found;
    logic             w_xfer;
    logic [IDW-1:0]   w_idx;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;

    // Window is forced shut during preset so req_ready reads 0 while reset is held.
    assign w_open = !preset && ((r_state == EMPTY) || rsp_ready);

    always_comb begin
        int unsigned j;
        j       = 0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(r_ptr) + k;
            if (j >= N) j = j - N;
            if (!w_found && req_valid[j]) begin
                w_found = 1'b1;
                w_idx   = j[IDW-1:0];
            end
        end
    end

    assign w_xfer    = w_found && w_open;
    assign w_a       = req_a[w_idx*WIDTH +: WIDTH];
    assign w_b       = req_b[w_idx*WIDTH +: WIDTH];
    // Shift amounts of WIDTH or more shift every bit out, yielding 0.
    assign w_result  = req_op[w_idx] ? (w_a << w_b) : (w_a + w_b);
    assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    assign req_ready = w_xfer ? (NREQ'(1) << w_idx) : '0;

    always_ff @(posedge clocked_on or posedge preset) begin
        if (preset) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_data  <= '0;
            r_id    <= '0;
        end else if (w_xfer) begin
            r_state <= FULL;
            r_ptr   <= w_ptr_nxt;
            r_data  <= w_result;
            r_id    <= w_idx;
        end else if ((r_state == FULL) && rsp_ready) begin
            r_state <= EMPTY;
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;
    assign busy      = rsp_valid || (|req_valid);

`ifdef UMICH_ARB_STATS_EN
    logic [NREQ*16-1:0] r_grant_cnt;

    // Clear has priority over a same-cycle grant; counters saturate at all-ones.
    always_ff @(posedge clocked_on or posedge preset) begin
        if (preset) begin
            r_grant_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (stats_clr)
                    r_grant_cnt[i*16 +: 16] <= '0;
                else if (req_ready[i] && (r_grant_cnt[i*16 +: 16] != 16'hFFFF))
                    r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_umich_add_arbiter.sv
// Directed self-checking bench for umich_add_arbiter (NREQ=4, WIDTH=64).
// Stats checks run only when UMICH_ARB_STATS_EN is defined.
module tb_umich_add_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 64;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  preset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;
`ifdef UMICH_ARB_STATS_EN
    logic [NREQ*16-1:0]    grant_cnt;
    logic                  stats_clr;
`endif

    int n_pass;
    int n_total;

    umich_add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clocked_on (clk),
        .preset     (preset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
`ifdef UMICH_ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt),
        .stats_clr  (stats_clr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic op,
                           input logic [63:0] a, input logic [63:0] b);
        req_valid[i]           = v;
        req_op[i]              = op;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic load_all_add();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, 1'b0, 64'h100 * (i + 1), 64'(i + 1));
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        preset    = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
`ifdef UMICH_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        tick();
        tick();
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_data",  rsp_data, 64'd0);
        check("rst_rsp_id",    64'(rsp_id), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);

        // Fill the output register, then reset asynchronously mid-cycle.
        preset = 1'b0;
        load_all_add();
        #1;
        check("first_grant", 64'(req_ready), 64'b0001);
        tick();
        check("fill_valid", 64'(rsp_valid), 64'd1);
        check("fill_data",  rsp_data, 64'h101);
        check("full_noready", 64'(req_ready), 64'd0);
        #2;
        preset = 1'b1;
        #1;
        check("async_rsp_valid", 64'(rsp_valid), 64'd0);
        check("async_req_ready", 64'(req_ready), 64'd0);
        check("async_rsp_data",  rsp_data, 64'd0);
        tick();
        preset    = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("post_rst_grant", 64'(req_ready), 64'b0001);
        tick();
        check("post_rst_id", 64'(rsp_id), 64'd0);
        req_valid = '0;
        tick();
        check("drain_valid", 64'(rsp_valid), 64'd0);

        // Single add with carry-out discarded (pointer now 1).
        set_req(2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        #1;
        check("add_grant", 64'(req_ready), 64'b0100);
        tick();
        check("add_valid", 64'(rsp_valid), 64'd1);
        check("add_data",  rsp_data, 64'd0);
        check("add_id",    64'(rsp_id), 64'd2);
        req_valid = '0;

        // Shift bounds (pointer now 3, wraps to find requester 1).
        set_req(1, 1'b1, 1'b1, 64'h1, 64'd63);
        #1;
        check("shl_grant", 64'(req_ready), 64'b0010);
        tick();
        check("shl63_data", rsp_data, 64'h8000_0000_0000_0000);
        check("shl63_id",   64'(rsp_id), 64'd1);
        set_req(1, 1'b1, 1'b1, 64'h1, 64'd64);
        tick();
        check("shl64_data", rsp_data, 64'd0);
        set_req(1, 1'b1, 1'b1, 64'h1, 64'd0);
        tick();
        check("shl0_data", rsp_data, 64'h1);
        req_valid = '0;
        tick();
        check("idle_valid", 64'(rsp_valid), 64'd0);
        check("idle_keep_data", rsp_data, 64'h1);

        // Round-robin from a fresh pointer.
        preset = 1'b1;
        tick();
        preset = 1'b0;
        load_all_add();
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_valid", 64'(rsp_valid), 64'd1);
            check("rr_id",    64'(rsp_id), 64'(k % 4));
            check("rr_data",  rsp_data, 64'h101 * 64'((k % 4) + 1));
        end
        req_valid = '0;
        tick();

        // Backpressure then same-cycle drain and refill (pointer now 0).
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 64'd5, 64'd7);
        tick();
        set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_req(3, 1'b1, 1'b1, 64'd3, 64'd4);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_data",  rsp_data, 64'd12);
            check("bp_id",    64'(rsp_id), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_grant", 64'(req_ready), 64'b1000);
        tick();
        check("bp_new_valid", 64'(rsp_valid), 64'd1);
        check("bp_new_data",  rsp_data, 64'h30);
        check("bp_new_id",    64'(rsp_id), 64'd3);
        req_valid = '0;
        tick();
        check("final_busy", 64'(busy), 64'd0);

`ifdef UMICH_ARB_STATS_EN
        preset = 1'b1;
        tick();
        preset = 1'b0;
        set_req(0, 1'b1, 1'b0, 64'd1, 64'd1);
        for (int k = 0; k < 70000; k++) @(posedge clk);
        #1;
        check("cnt0_sat",  64'(grant_cnt[15:0]), 64'hFFFF);
        check("cnt_other", 64'(grant_cnt[63:16]), 64'd0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        req_valid = '0;
        check("cnt_clr", 64'(grant_cnt), 64'd0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/umich_add_arbiter.md
Name: umich_add_arbiter

Overview:
Round-robin arbiter and sequencer that shares one unsigned adder (A+B) and one left shifter (A<<SH) among NREQ requesters. Each requester uses a valid/ready handshake. The winning request is computed and captured in a single-entry output register, which drains through a valid/ready response port tagged with the requester index. The block sits between the synthesized operator datapath and the client blocks that need occasional wide arithmetic.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 64, operand and result width in bits
IDW, $clog2(NREQ), width of the requester index tag (derived)

Ports:
clocked_on  input  1  clock, rising edge
preset  input  1  reset, asynchronous, active-high
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester grant/accept, one-hot or zero
req_op  input  NREQ  per-requester op select: 0 = add, 1 = shift left
req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  operand B (addend, or shift amount), same packing
rsp_valid  output  1  result register holds a valid result
rsp_ready  input  1  consumer accepts the result
rsp_data  output  WIDTH  result
rsp_id  output  IDW  index of the requester that produced rsp_data
busy  output  1  high when rsp_valid is high or any req_valid is high

Behaviour:
- Reset: preset is asynchronous and active-high; clock is clocked_on.
  - While preset is high: rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0.
  - Round-robin pointer resets to 0, so requester 0 has highest priority first.
- Output register FSM has two states, EMPTY and FULL. The reset state is EMPTY.
- The accept window is open when the state is EMPTY, or when the state is FULL and rsp_ready=1 (same-cycle drain and refill).
- Grant:
  - In an open window, req_ready is asserted combinationally for exactly one i with req_valid[i]=1.
  - i is the first valid requester searching upward from the pointer, wrapping NREQ-1 -> 0.
  - No valid requester, or a closed window -> req_ready=0.
- A transfer occurs when req_valid[i] and req_ready[i] are both high.
- On a transfer edge:
  - rsp_data <= op result, rsp_id <= i, rsp_valid <= 1, state FULL.
  - pointer <= (i+1) mod NREQ.
- Latency: 1 cycle from the accept edge to rsp_valid. Throughput: 1 result per cycle while rsp_ready=1.
- FULL with rsp_ready=0:
  - rsp_data, rsp_id and rsp_valid hold stable.
  - req_ready=0 and the pointer is unchanged.
- FULL with rsp_ready=1 and no valid requester: next state is EMPTY and rsp_valid=0. rsp_data and rsp_id keep their last values.
- The pointer advances only on a transfer. An idle cycle never moves it.
- Arithmetic:
  - Add is modulo 2^WIDTH; the carry is discarded.
  - Shift is logical left by the full unsigned value of B. B >= WIDTH gives 0. B=0 gives A.
- Requester rules:
  - A requester holds req_valid, req_op, req_a and req_b stable until accepted.
  - A requester that drops req_valid before acceptance forfeits its turn; no state is kept for it.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, the grant order is 0,1,...,NREQ-1,0,...; the worst-case wait is NREQ-1 grants.
- Reset mid-operation: any FULL result is discarded, rsp_valid drops asynchronously, and the pointer returns to 0.
- busy is combinational from rsp_valid and req_valid.

Optional Feature:
UMICH_ARB_STATS_EN
- Defined:
  - Adds output grant_cnt, NREQ*16 bits: one 16-bit counter per requester, packed like req_a.
  - A counter increments on each transfer for its requester and saturates at 16'hFFFF.
  - All counters clear to 0 on preset.
  - Adds input stats_clr (1 bit); stats_clr=1 clears all counters synchronously. A grant in the same cycle loses: the counter reads 0.
- Undefined: grant_cnt and stats_clr are absent, and the logic is identical otherwise.

Test Plan:
- Reset: assert preset mid-cycle with req_valid=4'b1111 -> rsp_valid, req_ready and rsp_data go to 0 immediately. After release, the first grant goes to requester 0.
- Single add: req 2 valid, op=0, A=64'hFFFF_FFFF_FFFF_FFFF, B=1, rsp_ready=1 -> req_ready=4'b0100 that cycle. Next cycle rsp_valid=1, rsp_data=0, rsp_id=2.
- Shift bounds: req 1 op=1, A=64'h1, B=63 -> rsp_data=64'h8000_0000_0000_0000. Then B=64 -> 0. Then B=0 -> 64'h1.
- Round-robin: all four valid, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3 with one result per cycle.
- Backpressure: FULL, rsp_ready=0 for 3 cycles while req 3 is valid -> rsp_data and rsp_id stable and req_ready=0. Raise rsp_ready -> same-cycle drain and accept, and the req 3 result appears the next cycle.
- Stats (UMICH_ARB_STATS_EN): 70000 grants to req 0 -> grant_cnt[15:0]=16'hFFFF. Pulse stats_clr -> all counters 0.
